counter_updn: RTL and testbench
===============================

COUNTER_UPDN -- requirements
Module: counter_updn

Interface
REQ-001 Parameter WIDTH, default 8, sets the counter width in bits; legal range 2..32.
REQ-002 clk50m  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 en  input  1  count enable; 1 = count this cycle, 0 = hold.
REQ-005 down  input  1  direction; 0 = increment, 1 = decrement.
REQ-006 cnt  output  WIDTH  current count value, driven directly from a register.
REQ-007 tc  output  1  terminal-count flag; present only when COUNTER_UPDN_TC_EN is defined.
REQ-008 The block has one clock (clk50m); reset rst_n is asynchronous and active-low.

Function
REQ-009 With rst_n=1, en=1, down=0, cnt SHALL become cnt+1 at each rising edge of clk50m.
REQ-010 With rst_n=1, en=1, down=1, cnt SHALL become cnt-1 at each rising edge of clk50m.
REQ-011 With en=0, cnt SHALL hold its value regardless of down.
REQ-012 Up count wrap: at 2^WIDTH-1, the next increment SHALL give 0, with no saturation and no stall.
REQ-013 Down count wrap: at 0, the next decrement SHALL give 2^WIDTH-1.
REQ-014 Latency is one cycle: en and down are sampled at the rising edge, and the new cnt is visible after that edge.
REQ-015 If down changes while en=1, it SHALL take effect at the next rising edge, with no dead cycle.
REQ-016 Arithmetic is modulo 2^WIDTH; there are no other outputs and no carry out, apart from tc.
REQ-017 tc SHALL be 1 when en=1 and the next edge will wrap, i.e. (down=0 and cnt=2^WIDTH-1) or (down=1 and cnt=0); otherwise tc SHALL be 0.
REQ-018 tc is combinational from en, down and cnt, with no registered delay.

Reset
REQ-019 rst_n=0 SHALL force cnt to 0 immediately, without waiting for a clock edge.
REQ-020 While rst_n=0, cnt SHALL stay 0 regardless of en and down.
REQ-021 Counting SHALL resume from 0 at the first rising edge at which rst_n=1 and en=1.
REQ-022 Reset asserted mid-count SHALL discard the count state, with no partial update.
REQ-023 tc SHALL be 0 during reset.

Configuration
REQ-024 The macro COUNTER_UPDN_TC_EN controls the tc feature.
REQ-025 With COUNTER_UPDN_TC_EN defined, the tc port and its logic are present per REQ-017.
REQ-026 Without COUNTER_UPDN_TC_EN, the tc port and its logic are absent, and the cnt behaviour is unchanged.

Structure
REQ-027 Package counter_updn_pkg SHALL hold:
- the direction enum (DIR_UP=0, DIR_DOWN=1);
- the default-width constant (CNT_WIDTH_DEFAULT=8).
REQ-028 Sub-module counter_updn_next (combinational) SHALL compute the next value and the wrap condition from cnt, en and down.
REQ-029 The top level SHALL hold only the state register and the reset logic.

Verification (use WIDTH=6)
REQ-030 Reset check: rst_n=0 with en=1 for 5 edges -> cnt=0 throughout; release rst_n with en=1 -> cnt=1 after the first edge.
REQ-031 Up count: from 0, en=1, down=0 for 100 edges -> one wrap (63->0) is observed, and final cnt=36.
REQ-032 Down count: from 36, en=1, down=1 for 200 edges -> wraps 0->63 occur, and final cnt=28 (36-200 mod 64).
REQ-033 Hold: en=0 for 10 edges at cnt=17, toggling down -> cnt stays 17.
REQ-034 Mid-count reset: assert rst_n=0 between edges at cnt=40 -> cnt=0 before the next edge.
REQ-035 With COUNTER_UPDN_TC_EN defined:
- tc=1 at cnt=63 with down=0 and en=1;
- tc=1 at cnt=0 with down=1 and en=1;
- tc=0 when en=0.

Source files
------------

// File: rtl/counter_updn_pkg.sv
// Shared types and constants for the up/down counter.
// Holds the direction encoding and the default counter width.
package counter_updn_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int CNT_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/counter_updn_next.sv
// Combinational next-state logic for counter_updn: next count and the
// "next edge wraps" condition, both modulo 2^WIDTH.
module counter_updn_next
  import counter_updn_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             en,
  input  logic             down,
  output logic [WIDTH-1:0] cnt_next,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  dir_e dir;
  assign dir = dir_e'(down);

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_next = cnt;
    wrap     = 1'b0;
    if (en) begin
      if (dir == DIR_DOWN) begin
        cnt_next = cnt - CNT_ONE;
        wrap     = (cnt == '0);
      end else begin
        cnt_next = cnt + CNT_ONE;
        wrap     = (cnt == CNT_MAX);
      end
    end
  end

endmodule

// File: rtl/counter_updn.sv
// Modulo-2^WIDTH up/down counter with enable; state register and reset only.
// Optional terminal-count output tc is built when COUNTER_UPDN_TC_EN is defined.
module counter_updn
  import counter_updn_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic             clk50m,
  input  logic             rst_n,
  input  logic             en,
  input  logic             down,
  output logic [WIDTH-1:0] cnt
`ifdef COUNTER_UPDN_TC_EN
  ,
  output logic             tc
`endif
);

  logic [WIDTH-1:0] cnt_next;

`ifdef COUNTER_UPDN_TC_EN
  logic wrap;
`else
  logic wrap_unused;
`endif

  counter_updn_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .cnt      (cnt),
    .en       (en),
    .down     (down),
    .cnt_next (cnt_next),
`ifdef COUNTER_UPDN_TC_EN
    .wrap     (wrap)
`else
    .wrap     (wrap_unused)
`endif
  );

  // NOTE: sequential state uses non-blocking assignment; async reset clears it at once.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

`ifdef COUNTER_UPDN_TC_EN
  // Held low during reset even though cnt=0 with down=1 would otherwise flag a wrap.
  assign tc = wrap & rst_n;
`endif

endmodule

// File: tb/tb_counter_updn.sv
// Directed self-checking bench for counter_updn at WIDTH=6.
// tc checks are compiled in only when COUNTER_UPDN_TC_EN is defined.
module tb_counter_updn;

  localparam int WIDTH = 6;

  logic             clk50m;
  logic             rst_n;
  logic             en;
  logic             down;
  logic [WIDTH-1:0] cnt;
`ifdef COUNTER_UPDN_TC_EN
  logic             tc;
`endif

  int checks_total;
  int checks_passed;

  counter_updn #(
    .WIDTH (WIDTH)
  ) dut (
    .clk50m (clk50m),
    .rst_n  (rst_n),
    .en     (en),
    .down   (down),
    .cnt    (cnt)
`ifdef COUNTER_UPDN_TC_EN
    ,
    .tc     (tc)
`endif
  );

  initial clk50m = 1'b0;
  always #10 clk50m = ~clk50m;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk50m);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] prev;
    int               wraps;

    checks_total  = 0;
    checks_passed = 0;

    // Reset with en=1: cnt stays 0 across 5 edges.
    rst_n = 1'b0;
    en    = 1'b1;
    down  = 1'b1;
    #3;
    check("reset_initial", 32'(cnt), 32'd0);
`ifdef COUNTER_UPDN_TC_EN
    check("tc_in_reset", 32'(tc), 32'd0);
`endif
    for (int i = 0; i < 5; i++) begin
      step(1);
      check($sformatf("reset_hold_%0d", i), 32'(cnt), 32'd0);
    end
    down  = 1'b0;
    rst_n = 1'b1;
    step(1);
    check("reset_release_first", 32'(cnt), 32'd1);

    // Return to 0 then count up 100 edges: one wrap, final 36.
    rst_n = 1'b0;
    #2;
    check("rerst_zero", 32'(cnt), 32'd0);
    rst_n = 1'b1;
    wraps = 0;
    for (int i = 0; i < 100; i++) begin
`ifdef COUNTER_UPDN_TC_EN
      if (i == 63) check("tc_up_at_63", 32'(tc), 32'd1);
      if (i == 62) check("tc_up_at_62", 32'(tc), 32'd0);
`endif
      prev = cnt;
      step(1);
      if (prev == 6'd63 && cnt == 6'd0) wraps++;
    end
    check("up_wraps", 32'(wraps), 32'd1);
    check("up_final", 32'(cnt), 32'd36);

    // Count down 200 edges from 36: wraps at 36, 100, 164 -> 3; final 28.
    down  = 1'b1;
    wraps = 0;
    for (int i = 0; i < 200; i++) begin
`ifdef COUNTER_UPDN_TC_EN
      if (i == 36) check("tc_down_at_0", 32'(tc), 32'd1);
      if (i == 35) check("tc_down_at_1", 32'(tc), 32'd0);
`endif
      prev = cnt;
      step(1);
      if (prev == 6'd0 && cnt == 6'd63) wraps++;
    end
    check("down_wraps", 32'(wraps), 32'd3);
    check("down_final", 32'(cnt), 32'd28);

    // 28 - 11 = 17, then hold 10 edges while toggling down.
    step(11);
    check("reach_17", 32'(cnt), 32'd17);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      down = ~down;
`ifdef COUNTER_UPDN_TC_EN
      #1;
      check($sformatf("tc_en0_%0d", i), 32'(tc), 32'd0);
`endif
      step(1);
    end
    check("hold_17", 32'(cnt), 32'd17);

    // Direction change while enabled takes effect on the very next edge.
    en   = 1'b1;
    down = 1'b0;
    step(1);
    check("dir_up_18", 32'(cnt), 32'd18);
    down = 1'b1;
    step(1);
    check("dir_down_17", 32'(cnt), 32'd17);

    // Count up to 40, then reset between edges.
    down = 1'b0;
    step(23);
    check("reach_40", 32'(cnt), 32'd40);
    #5;
    rst_n = 1'b0;
    #1;
    check("midcount_reset_async", 32'(cnt), 32'd0);
    step(2);
    check("midcount_reset_hold", 32'(cnt), 32'd0);

    // Release with en=0, then resume from 0.
    en    = 1'b0;
    rst_n = 1'b1;
    step(1);
    check("release_en0", 32'(cnt), 32'd0);
    en = 1'b1;
    step(1);
    check("resume_from_0", 32'(cnt), 32'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
